// File: rtl/dec_pkg.sv
// Shared LEGv8 decode types: format enumeration, opcode constants and the
// decoded-bundle struct carried through the decode stage's skid buffer.
package dec_pkg;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_D       = 3'd2,
        FMT_B       = 3'd3,
        FMT_CB      = 3'd4,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OPC_SUBIS = 10'b1111000100;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_ADD   = 11'b10001011000;
    localparam logic [10:0] OPC_SUB   = 11'b11001011000;
    localparam logic [10:0] OPC_AND   = 11'b10001010000;
    localparam logic [10:0] OPC_ORR   = 11'b10101010000;
    localparam logic [10:0] OPC_LSL   = 11'b11010011011;
    localparam logic [10:0] OPC_LSR   = 11'b11010011010;

    localparam int unsigned IMM_W = 26;

    // imm is held as a 26-bit value that is always correct to sign-extend:
    // zero-extended I-format immediates keep bit 25 clear.
    typedef struct packed {
        fmt_e             fmt;
        logic [10:0]      opcode;
        logic [4:0]       rm;
        logic [4:0]       rn;
        logic [4:0]       rt;
        logic [5:0]       shamt;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } dec_bundle_t;

endpackage

// File: rtl/dec_fields.sv
// Combinational LEGv8 field decode: instruction word -> decoded bundle.
module dec_fields
    import dec_pkg::*;
(
    input  logic [31:0] instr,
    output dec_bundle_t bundle
);

    always_comb begin
        bundle = '0;
        if (instr[31:26] == OPC_B) begin
            bundle.fmt    = FMT_B;
            bundle.opcode = {5'b0, instr[31:26]};
            bundle.imm    = instr[25:0];
        end else if (instr[31:24] == OPC_CBZ || instr[31:24] == OPC_CBNZ) begin
            bundle.fmt    = FMT_CB;
            bundle.opcode = {3'b0, instr[31:24]};
            bundle.imm    = {{7{instr[23]}}, instr[23:5]};
            bundle.rt     = instr[4:0];
        end else if (instr[31:22] == OPC_ADDI || instr[31:22] == OPC_ADDIS ||
                     instr[31:22] == OPC_SUBI || instr[31:22] == OPC_SUBIS) begin
            bundle.fmt    = FMT_I;
            bundle.opcode = {1'b0, instr[31:22]};
            bundle.imm    = {14'b0, instr[21:10]};
            bundle.rn     = instr[9:5];
            bundle.rt     = instr[4:0];
        end else if (instr[31:21] == OPC_LDUR || instr[31:21] == OPC_STUR) begin
            bundle.fmt    = FMT_D;
            bundle.opcode = instr[31:21];
            bundle.imm    = {{17{instr[20]}}, instr[20:12]};
            bundle.rn     = instr[9:5];
            bundle.rt     = instr[4:0];
        end else if (instr[31:21] == OPC_ADD || instr[31:21] == OPC_SUB ||
                     instr[31:21] == OPC_AND || instr[31:21] == OPC_ORR ||
                     instr[31:21] == OPC_LSL || instr[31:21] == OPC_LSR) begin
            bundle.fmt    = FMT_R;
            bundle.opcode = instr[31:21];
            bundle.rm     = instr[20:16];
            bundle.shamt  = instr[15:10];
            bundle.rn     = instr[9:5];
            bundle.rt     = instr[4:0];
        end else begin
            bundle.fmt     = FMT_ILLEGAL;
            bundle.opcode  = instr[31:21];
            bundle.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// LEGv8 decode stage: dec_fields decode, 2-entry skid buffer, flush.
// Optional performance counters enabled by defining DEC_PERF_CNT_EN.
module id_decode_stage
    import dec_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PC_W   = 64
`ifdef DEC_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_fmt,
    output logic [10:0]       out_opcode,
    output logic [4:0]        out_rm,
    output logic [4:0]        out_rn,
    output logic [4:0]        out_rt,
    output logic [5:0]        out_shamt,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_illegal,
    output logic [PC_W-1:0]   out_pc
`ifdef DEC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  out_cnt_instr,
    output logic [CNT_W-1:0]  out_cnt_illegal
`endif
);

    dec_bundle_t     dec;
    dec_bundle_t     main_q;
    dec_bundle_t     skid_q;
    logic [PC_W-1:0] main_pc;
    logic [PC_W-1:0] skid_pc;
    logic            main_valid;
    logic            skid_valid;
    logic            accept;
    logic            main_free;

    dec_fields u_fields (
        .instr  (in_instr),
        .bundle (dec)
    );

    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    // The skid entry only fills while main is held, so in_ready is low
    // whenever skid data is pending and the refill path never races an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            main_pc    <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_pc    <= skid_pc;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec;
                main_pc    <= in_pc;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_pc    <= in_pc;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_fmt     = main_q.fmt;
    assign out_opcode  = main_q.opcode;
    assign out_rm      = main_q.rm;
    assign out_rn      = main_q.rn;
    assign out_rt      = main_q.rt;
    assign out_shamt   = main_q.shamt;
    assign out_imm     = DATA_W'($signed(main_q.imm));
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_pc;

`ifdef DEC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt_instr   <= '0;
            out_cnt_illegal <= '0;
        end else if (accept && !flush) begin
            out_cnt_instr <= out_cnt_instr + 1'b1;
            if (dec.illegal) begin
                out_cnt_illegal <= out_cnt_illegal + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
Pipelined, parametrised LEGv8 instruction-decode stage between fetch and execute. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Classifies it into R/I/D/B/CB/illegal format, extracts register fields, and sign- or zero-extends the immediate to DATA_W. Results are registered with a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush supports branch redirect.

Parameters:
DATA_W, 64, width of out_imm (must be >= 26)
PC_W, 64, width of in_pc/out_pc
CNT_W, 32, width of performance counters (used only with DEC_PERF_CNT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
flush  in  1  drop all held/incoming instructions this cycle
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  PC_W  PC of instruction
out_valid  out  1  decoded bundle available
out_ready  in  1  execute accepts bundle
out_fmt  out  3  0=R 1=I 2=D 3=B 4=CB 7=ILLEGAL
out_opcode  out  11  opcode, right-justified, zero-padded
out_rm  out  5  second source (R only, else 0)
out_rn  out  5  first source (R/I/D, else 0)
out_rt  out  5  dest/data reg (R/I/D/CB, else 0)
out_shamt  out  6  shift amount (R only, else 0)
out_imm  out  DATA_W  extended immediate
out_illegal  out  1  unrecognised opcode
out_pc  out  PC_W  PC passed through
out_cnt_instr  out  CNT_W  accepted-instruction count (DEC_PERF_CNT_EN only)
out_cnt_illegal  out  CNT_W  illegal-instruction count (DEC_PERF_CNT_EN only)

Behaviour:
- Reset (rst_n=0 at clk edge): both buffer entries invalid; out_valid=0, in_ready=1; all out_* data fields 0; counters 0.
- Decode is combinational on in_instr. Field decisions, first match wins:
  - B: [31:26]=000101; imm=sext([25:0]).
  - CB: [31:24]=10110100 (CBZ) or 10110101 (CBNZ); imm=sext([23:5]); rt=[4:0].
  - I: [31:22] in {1001000100 ADDI, 1011000100 ADDIS, 1101000100 SUBI, 1111000100 SUBIS}; imm=zext([21:10]); rn=[9:5]; rt=[4:0].
  - D: [31:21] in {11111000010 LDUR, 11111000000 STUR}; imm=sext([20:12]); op2 [11:10] ignored; rn=[9:5]; rt=[4:0].
  - R: [31:21] in {10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR, 11010011011 LSL, 11010011010 LSR}; rm=[20:16]; shamt=[15:10]; rn=[9:5]; rt=[4:0]; imm=0.
  - Otherwise: fmt=7, out_illegal=1, all fields 0, opcode=[31:21].
- Every output field is driven in every case; no latches.
- Latency: 1 cycle. An accepted instruction (in_valid&in_ready) at edge N is presented at out_valid from N+1.
- Skid buffer: main entry drives outputs; skid entry catches input when main is held (out_valid&!out_ready).
- in_ready is registered: in_ready = !skid_valid.
- Ordering is preserved; skid data moves to main when main drains.
- Throughput: 1/cycle while out_ready=1.
- Output hold: while out_valid&!out_ready, all out_* remain stable.
- Flush: highest priority below reset. Both entries are invalidated at the edge, and the same-cycle input handshake is discarded. Next cycle: out_valid=0, in_ready=1.
- Simultaneous drain and accept with skid empty: main is replaced by the new instruction, with no bubble.

Optional Feature:
DEC_PERF_CNT_EN
- Defined: out_cnt_instr increments on each non-flushed accept; out_cnt_illegal increments when that instruction decodes illegal. Both wrap modulo 2^CNT_W, are cleared by reset, and are not cleared by flush.
- Undefined: counter ports and logic are absent.

Decomposition:
- Package dec_pkg holds:
  - the fmt enumeration;
  - opcode constants (OPC_B, OPC_CBZ, OPC_CBNZ, OPC_ADDI, OPC_ADDIS, OPC_SUBI, OPC_SUBIS, OPC_LDUR, OPC_STUR, OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_LSL, OPC_LSR);
  - the decoded-bundle struct.
- Sub-module dec_fields: purely combinational instr -> bundle decode. The top holds the skid buffer, handshake and counters.

Test Plan:
- Reset, then ADDI 0x91002841 with out_ready=1 -> next cycle fmt=1, opcode=0x244, imm=10, rn=2, rt=1.
- LDUR 0xF85F8020 -> fmt=2, imm=-8 sign-extended (0xFFFF_FFFF_FFFF_FFF8), rn=1, rt=0.
- CBZ 0xB4FFFFE3 -> fmt=4, imm=all ones (-1), rt=3; B 0x17FFFFFF -> fmt=3, imm=-1.
- Stream 4 instrs with out_ready=0 from cycle 2 -> in_ready drops after 2 accepts. Releasing out_ready yields the order preserved, no loss, no duplicate.
- Flush while both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped input never appears.
- Word 0x00000000 -> fmt=7, out_illegal=1. With DEC_PERF_CNT_EN, after 5 accepts including 1 illegal: cnt_instr=5, cnt_illegal=1.
